uart_receiver: RTL and testbench

UART receive stage that consumes the serial line driven by `uart_transmitter`. It synchronises the line, detects and qualifies a start bit, and samples 8 data bits LSB-first at mid-bit using the same `comp` baud divisor convention (bit period = comp+1 clocks). Each checked byte is presented on a valid/ack handshake, and framing and overrun errors are flagged. It sits between the pad/loopback line and the core's receive data path.

---
 rtl/uart_receiver.sv | 163 ++++++++++++++++
 tb/tb_uart_receiver.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_receiver.sv
// UART receive stage: two-flop line synchroniser, mid-bit sampling FSM and a
// valid/ack output register with framing-error and overrun pulses.
module uart_receiver (
    input  logic        clk,
    input  logic        resetn,
    input  logic [15:0] comp,
    input  logic        rec_en,
    input  logic        uart_rx,
    output logic [7:0]  rx_data,
    output logic        rx_valid,
    input  logic        rx_ack,
    output logic        frame_err,
    output logic        overrun
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_START   = 3'd1,
        S_RECEIVE = 3'd2,
        S_STOP    = 3'd3,
        S_WAIT    = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  sync_q;
    logic [15:0] comp_int_q, comp_int_d;
    logic [15:0] comp_c_q, comp_c_d;
    logic [3:0]  bit_c_q, bit_c_d;
    logic [7:0]  shift_q, shift_d;
    logic [7:0]  rx_data_q, rx_data_d;
    logic        rx_valid_q, rx_valid_d;
    logic        frame_err_q, frame_err_d;
    logic        overrun_q, overrun_d;

    logic        rx_s;
    logic        deliver;
    logic [15:0] half_point;
    logic [15:0] stop_point;

    assign rx_s       = sync_q[1];
    assign half_point = {1'b0, comp_int_q[15:1]};
    // Stop sample sits a quarter bit into the stop bit so a half-bit stop is still caught.
    assign stop_point = half_point + {2'b00, comp_int_q[15:2]};

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sync_q      <= 2'b11;
            state_q     <= S_IDLE;
            comp_int_q  <= '0;
            comp_c_q    <= '0;
            bit_c_q     <= '0;
            shift_q     <= '0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            sync_q      <= {sync_q[0], uart_rx};
            state_q     <= state_d;
            comp_int_q  <= comp_int_d;
            comp_c_q    <= comp_c_d;
            bit_c_q     <= bit_c_d;
            shift_q     <= shift_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        comp_int_d  = comp_int_q;
        comp_c_d    = comp_c_q + 16'd1;
        bit_c_d     = bit_c_q;
        shift_d     = shift_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = rx_valid_q;
        frame_err_d = 1'b0;
        overrun_d   = 1'b0;
        deliver     = 1'b0;

        case (state_q)
            S_IDLE: begin
                comp_c_d = '0;
                if (!rx_s) begin
                    comp_int_d = comp;
                    state_d    = S_START;
                end
            end
            S_START: begin
                if (comp_c_q >= half_point) begin
                    comp_c_d = '0;
                    state_d  = rx_s ? S_IDLE : S_RECEIVE;
                end
            end
            S_RECEIVE: begin
                if (comp_c_q >= comp_int_q) begin
                    comp_c_d = '0;
                    shift_d  = {rx_s, shift_q[7:1]};
                    if (bit_c_q == 4'd7) begin
                        bit_c_d = '0;
                        state_d = S_STOP;
                    end else begin
                        bit_c_d = bit_c_q + 4'd1;
                    end
                end
            end
            S_STOP: begin
                if (comp_c_q >= stop_point) begin
                    comp_c_d = '0;
                    if (rx_s) begin
                        deliver = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                comp_c_d = '0;
                if (rx_s) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                comp_c_d = '0;
                state_d  = S_IDLE;
            end
        endcase

        // A same-cycle ack frees the output register, so the new byte replaces the old one.
        if (deliver) begin
            if (!rx_valid_q || rx_ack) begin
                rx_data_d  = shift_q;
                rx_valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (rx_ack && rx_valid_q) begin
            rx_valid_d = 1'b0;
        end

        if (!rec_en) begin
            state_d     = S_IDLE;
            comp_int_d  = '0;
            comp_c_d    = '0;
            bit_c_d     = '0;
            shift_d     = '0;
            rx_data_d   = '0;
            rx_valid_d  = 1'b0;
            frame_err_d = 1'b0;
            overrun_d   = 1'b0;
        end
    end

    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_uart_receiver.sv
// Scoreboard bench for uart_receiver: a serial-line driver pushes the expected
// event of each frame, and a monitor pops and compares whenever the DUT reports one.
module tb_uart_receiver;

    localparam logic [1:0] EV_DATA = 2'd0;
    localparam logic [1:0] EV_FERR = 2'd1;
    localparam logic [1:0] EV_OVR  = 2'd2;
    localparam logic [1:0] EV_NONE = 2'd3;

    typedef struct packed {
        logic [1:0] kind;
        logic [7:0] data;
    } ev_t;

    logic        clk;
    logic        resetn;
    logic [15:0] comp;
    logic        rec_en;
    logic        uart_rx;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ack;
    logic        frame_err;
    logic        overrun;

    ev_t expQ[$];
    int  total = 0;
    int  bad = 0;
    int  dropCount = 0;
    int  ackReqCount = 0;
    bit  autoAck = 1'b0;

    uart_receiver dut (
        .clk       (clk),
        .resetn    (resetn),
        .comp      (comp),
        .rec_en    (rec_en),
        .uart_rx   (uart_rx),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ack    (rx_ack),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkValue(input string name, input logic [15:0] actual, input logic [15:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic checkOutput(input logic [1:0] kind, input logic [7:0] data);
        ev_t exp;
        total++;
        if (expQ.size() == 0) begin
            bad++;
            $display("[TB] FAIL unexpected_event: got kind=%0d data=%h, expected nothing", kind, data);
        end else begin
            exp = expQ.pop_front();
            if (exp.kind !== kind || exp.data !== data) begin
                bad++;
                $display("[TB] FAIL event: got kind=%0d data=%h, expected kind=%0d data=%h",
                         kind, data, exp.kind, exp.data);
            end
        end
    endtask

    // Monitor: a delivery is a rising rx_valid, or rx_valid staying high across an ack.
    initial begin
        logic prevValid;
        prevValid = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (resetn !== 1'b1) begin
                prevValid = 1'b0;
            end else begin
                if (rx_valid === 1'b1 && (!prevValid || rx_ack === 1'b1))
                    checkOutput(EV_DATA, rx_data);
                if (frame_err === 1'b1)
                    checkOutput(EV_FERR, 8'h00);
                if (overrun === 1'b1)
                    checkOutput(EV_OVR, 8'h00);
                if (frame_err === 1'b1 && overrun === 1'b1)
                    checkValue("pulse_exclusive", 16'd1, 16'd0);
                if (prevValid && rx_valid !== 1'b1)
                    dropCount++;
                prevValid = (rx_valid === 1'b1);
            end
        end
    end

    // Consumer: explicit pulse requests, or an automatic ack after a short random delay.
    initial begin
        int ackDone;
        int ackWait;
        ackDone = 0;
        ackWait = 0;
        rx_ack  = 1'b0;
        forever begin
            @(negedge clk);
            if (ackReqCount != ackDone) begin
                rx_ack = 1'b1;
                ackDone++;
            end else if (autoAck && rx_valid === 1'b1 && !rx_ack) begin
                if (ackWait == 0) begin
                    rx_ack  = 1'b1;
                    ackWait = $urandom_range(0, 4);
                end else begin
                    ackWait--;
                end
            end else begin
                rx_ack = 1'b0;
            end
        end
    end

    function automatic int stopLen(input int sel, input int period);
        case (sel)
            0:       return period / 2;
            1:       return period;
            2:       return (period * 3) / 2;
            default: return period * 2;
        endcase
    endfunction

    task automatic sendBits(input logic [7:0] b, input int period, input int stopCycles, input bit badStop);
        uart_rx = 1'b0;
        repeat (period) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            repeat (period) @(negedge clk);
        end
        uart_rx = !badStop;
        repeat (stopCycles) @(negedge clk);
        uart_rx = 1'b1;
    endtask

    task automatic applyStimulus(input logic [7:0] b, input int period, input int stopCycles,
                                 input bit badStop, input logic [1:0] expKind);
        if (expKind == EV_DATA)
            expQ.push_back('{kind: EV_DATA, data: b});
        else if (expKind != EV_NONE)
            expQ.push_back('{kind: expKind, data: 8'h00});
        @(negedge clk);
        sendBits(b, period, stopCycles, badStop);
        repeat ($urandom_range(2, 6)) @(negedge clk);
    endtask

    task automatic drain(input string name, input int limit);
        int n;
        n = 0;
        while (expQ.size() != 0 && n < limit) begin
            @(negedge clk);
            n++;
        end
        repeat (2) @(negedge clk);
        checkValue(name, 16'(expQ.size()), 16'd0);
        expQ.delete();
    endtask

    task automatic pulseAck();
        @(posedge clk);
        ackReqCount++;
        @(negedge clk);
        @(negedge clk);
    endtask

    initial begin
        #800000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        bad++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        logic [7:0] b;
        int         c;
        int         snap;
        resetn  = 1'b0;
        rec_en  = 1'b1;
        uart_rx = 1'b1;
        comp    = 16'd15;
        repeat (3) @(negedge clk);
        checkValue("reset_rx_data", {8'h00, rx_data}, 16'h0000);
        checkValue("reset_rx_valid", {15'd0, rx_valid}, 16'd0);
        checkValue("reset_frame_err", {15'd0, frame_err}, 16'd0);
        checkValue("reset_overrun", {15'd0, overrun}, 16'd0);
        resetn = 1'b1;
        repeat (4) @(negedge clk);

        $display("[TB] good byte with held valid");
        applyStimulus(8'hA5, 16, 16, 1'b0, EV_DATA);
        drain("drain_a5", 400);
        repeat (20) @(negedge clk);
        checkValue("hold_valid", {15'd0, rx_valid}, 16'd1);
        checkValue("hold_data", {8'h00, rx_data}, 16'h00A5);
        pulseAck();
        checkValue("valid_after_ack", {15'd0, rx_valid}, 16'd0);

        autoAck = 1'b1;
        for (int sel = 0; sel < 4; sel++) begin
            applyStimulus(8'h00, 16, stopLen(sel, 16), 1'b0, EV_DATA);
            applyStimulus(8'hFF, 16, stopLen(sel, 16), 1'b0, EV_DATA);
        end
        drain("drain_stop_sel", 800);

        $display("[TB] false start");
        @(negedge clk);
        uart_rx = 1'b0;
        repeat (4) @(negedge clk);
        uart_rx = 1'b1;
        repeat (40) @(negedge clk);
        checkValue("false_start_valid", {15'd0, rx_valid}, 16'd0);
        applyStimulus(8'h81, 16, 16, 1'b0, EV_DATA);
        drain("drain_after_false", 400);

        $display("[TB] framing error then recovery");
        applyStimulus(8'h3C, 16, 48, 1'b1, EV_FERR);
        applyStimulus(8'h5A, 16, 16, 1'b0, EV_DATA);
        drain("drain_frame", 600);

        $display("[TB] overrun");
        repeat (10) @(negedge clk);
        autoAck = 1'b0;
        applyStimulus(8'h11, 16, 16, 1'b0, EV_DATA);
        applyStimulus(8'h22, 16, 16, 1'b0, EV_OVR);
        drain("drain_overrun", 600);
        checkValue("overrun_keeps_data", {8'h00, rx_data}, 16'h0011);
        checkValue("overrun_keeps_valid", {15'd0, rx_valid}, 16'd1);
        pulseAck();

        $display("[TB] ack in deliver cycle");
        applyStimulus(8'h11, 16, 16, 1'b0, EV_DATA);
        drain("drain_pre_simul", 400);
        snap = dropCount;
        c = 15;
        expQ.push_back('{kind: EV_DATA, data: 8'h22});
        @(negedge clk);
        fork
            sendBits(8'h22, c + 1, c + 1, 1'b0);
            begin
                // two sync flops, half-bit start, eight bits, then the stop sample cycle
                repeat (4 + (c >> 1) + 8 * (c + 1) + (c >> 1) + (c >> 2)) @(posedge clk);
                ackReqCount++;
            end
        join
        repeat (4) @(negedge clk);
        drain("drain_simul", 200);
        checkValue("simul_data", {8'h00, rx_data}, 16'h0022);
        checkValue("simul_valid", {15'd0, rx_valid}, 16'd1);
        checkValue("simul_no_drop", 16'(dropCount - snap), 16'd0);

        $display("[TB] enable abort");
        b = {4'hF, 4'($urandom_range(0, 15))};
        @(negedge clk);
        fork
            sendBits(b, 16, 16, 1'b0);
            begin
                repeat (5 * 16 + 8) @(negedge clk);
                rec_en = 1'b0;
                @(negedge clk);
                checkValue("en_abort_valid", {15'd0, rx_valid}, 16'd0);
                checkValue("en_abort_data", {8'h00, rx_data}, 16'h0000);
                checkValue("en_abort_pulses", {14'd0, frame_err, overrun}, 16'd0);
                rec_en = 1'b1;
            end
        join
        repeat (4) @(negedge clk);
        applyStimulus(8'hC3, 16, 16, 1'b0, EV_DATA);
        drain("drain_after_en", 400);
        checkValue("en_next_data", {8'h00, rx_data}, 16'h00C3);

        $display("[TB] reset abort");
        b = {4'hF, 4'($urandom_range(0, 15))};
        @(negedge clk);
        fork
            sendBits(b, 16, 16, 1'b0);
            begin
                repeat (5 * 16 + 8) @(negedge clk);
                resetn = 1'b0;
                @(negedge clk);
                checkValue("rst_abort_valid", {15'd0, rx_valid}, 16'd0);
                checkValue("rst_abort_data", {8'h00, rx_data}, 16'h0000);
                resetn = 1'b1;
            end
        join
        repeat (4) @(negedge clk);
        applyStimulus(8'hC3, 16, 16, 1'b0, EV_DATA);
        drain("drain_after_rst", 400);
        checkValue("rst_next_data", {8'h00, rx_data}, 16'h00C3);
        pulseAck();

        $display("[TB] divisor latch");
        autoAck = 1'b1;
        expQ.push_back('{kind: EV_DATA, data: 8'h96});
        @(negedge clk);
        fork
            sendBits(8'h96, 16, 16, 1'b0);
            begin
                repeat (3 * 16 + 8) @(negedge clk);
                comp = 16'd7;
            end
        join
        repeat (3) @(negedge clk);
        applyStimulus(8'h69, 8, 8, 1'b0, EV_DATA);
        drain("drain_divisor", 400);

        $display("[TB] random frames");
        for (int n = 0; n < 40; n++) begin
            bit badStop;
            c       = $urandom_range(6, 24);
            comp    = 16'(c);
            b       = 8'($urandom);
            badStop = ($urandom_range(0, 7) == 0);
            applyStimulus(b, c + 1,
                          badStop ? 2 * (c + 1) : stopLen($urandom_range(0, 3), c + 1),
                          badStop, badStop ? EV_FERR : EV_DATA);
        end
        drain("drain_random", 2000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
